// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter: N requesters share one fifo write port in bursts of up to BURST_LEN words.
// Optional macro FIFO_WR_ARB_STATS_EN adds a saturating 16-bit write counter output (wr_count).
module fifo_wr_arb #(
  parameter int unsigned N         = 4,
  parameter int unsigned DW        = 8,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req,
  input  logic [N*DW-1:0]        data,
  input  logic                   fifo_full,
  output logic [N-1:0]           gnt,
  output logic                   fifo_wr,
  output logic [DW-1:0]          fifo_din,
  output logic [$clog2(N)-1:0]   owner,
  output logic                   busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [15:0]            wr_count
`endif
);

  localparam int unsigned OW = $clog2(N);
  localparam int unsigned CW = 5;
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST_LEN - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t        state;
  state_t        state_nx;
  logic [OW-1:0] last;
  logic [OW-1:0] pick;
  logic          found;
  logic [CW-1:0] cnt;
  logic          own_req;
  logic          own_gnt;
  logic          burst_end;

  assign own_req   = req[owner];
  assign own_gnt   = own_req & ~fifo_full;
  assign burst_end = ~own_req | (own_gnt & (cnt == CNT_LAST));

  // Rotating priority search starting just above the previous tenure holder
  always_comb begin
    int unsigned idx;
    pick  = last;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = (32'(last) + i) % N;
      if (!found && req[idx[OW-1:0]]) begin
        pick  = idx[OW-1:0];
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (found) state_nx = BURST;
      BURST:   if (burst_end) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Tenure bookkeeping: owner, last holder and per-tenure word count
  always_ff @(posedge clk) begin
    if (!rst) begin
      owner <= '0;
      last  <= OW'(N - 1);
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            owner <= pick;
            cnt   <= '0;
          end
        end
        BURST: begin
          if (burst_end)    last <= owner;
          else if (own_gnt) cnt  <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs are forced quiet while reset is being sampled so no write slips through
  always_comb begin
    gnt      = '0;
    busy     = 1'b0;
    fifo_din = data[DW-1:0];
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (owner == OW'(i)) fifo_din = data[i*DW +: DW];
      end
      if (state == BURST) begin
        busy       = 1'b1;
        gnt[owner] = own_gnt;
      end
    end
    fifo_wr = |gnt;
  end

`ifdef FIFO_WR_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst)                               wr_count <= '0;
    else if (fifo_wr && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
  end
`endif

endmodule
